can_tx_frame_serializer: RTL and testbench
==========================================

Name: can_tx_frame_serializer

Overview:
- Downstream consumer of the 13-byte CAN transmit buffer. On a transmit request it snapshots the buffer bytes and emits the frame bit by bit from SOF through the end of the CRC field.
- It applies bit stuffing and computes CRC-15 on the fly, one bit per tx_point tick.
- CRC delimiter, ACK, EOF, arbitration-loss detection and error signalling belong to the bit-stream controller that consumes tx_bit.

Parameters:
- STUFF_LEN, 5, number of consecutive identical bits after which a complement stuff bit is inserted.
- CRC_POLY, 15'h4599, CRC-15 generator polynomial (CAN 2.0).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- tx_request  input  1  one-cycle start pulse from the command logic
- abort_tx  input  1  abort the current frame
- tx_point  input  1  one-cycle tick per bit time; marks where the next bit is driven
- extended_mode  input  1  0 = BASIC layout, 1 = EXTENDED (PeliCAN) layout
- tx_data_0 … tx_data_12  input  8 each  transmit buffer contents
- tx_bit  output  1  serial bit to the bus logic (1 = recessive)
- tx_busy  output  1  a frame is in progress
- tx_done  output  1  one-cycle pulse after the last CRC/stuff bit period
- tx_crc  output  15  running CRC; final value valid when tx_done pulses

Behaviour:
- Reset values: tx_bit=1, tx_busy=0, tx_done=0, tx_crc=0, FSM=IDLE, stuff counter=0.

Start and snapshot:
- In IDLE, tx_request=1 and abort_tx=0 latches all 13 bytes plus extended_mode into shadow registers and sets tx_busy=1 on the next cycle.
- Buffer writes made during transmission have no effect on the frame.
- tx_request while tx_busy=1 is ignored.

Byte layout:
- BASIC: ID[10:3]=d0, ID[2:0]=d1[7:5], RTR=d1[4], DLC=d1[3:0], data=d2..d9.
- EXTENDED, FF=d0[7], RTR=d0[6], DLC=d0[3:0]:
  - FF=0: ID[10:3]=d1, ID[2:0]=d2[7:5], data=d3..d10.
  - FF=1: ID[28:21]=d1, ID[20:13]=d2, ID[12:5]=d3, ID[4:0]=d4[7:3], data=d5..d12.

Bit sequence (unstuffed, MSB first):
- Standard frame, 19 header bits: SOF=0, ID[10:0], RTR, IDE=0, r0=0, DLC[3:0].
- Extended frame, 39 header bits: SOF=0, ID[28:18], SRR=1, IDE=1, ID[17:0], RTR, r1=0, r0=0, DLC[3:0].
- Data field: 8*min(DLC,8) bits. None when RTR=1. DLC>8 is sent unchanged in the DLC field.
- CRC field: CRC[14:0], MSB first.

FSM states: IDLE, HDR, DATA, CRC, FIN.
- IDLE→HDR on start.
- HDR→DATA at the end of the header, or directly to CRC when there are 0 data bytes.
- DATA→CRC after the last data bit.
- CRC→FIN after CRC bit 0 and any stuff bit that follows it.
- FIN→IDLE on the next tx_point. At that transition tx_done=1 for one cycle, tx_busy=0 and tx_bit=1.

Timing:
- tx_bit changes only in the cycle after a tx_point. The first tx_point after start drives SOF.
- A tx_point coincident with tx_request in IDLE does not drive SOF; SOF waits for the next tx_point.

CRC:
- Initialised to 0 at start.
- Updated once per unstuffed bit from SOF to the last data bit: crc_nxt = crc[14] ^ bit; crc = {crc[13:0],1'b0} ^ (crc_nxt ? CRC_POLY : 0).
- Frozen during the CRC field and stuff bits.

Stuffing:
- Applies to every driven bit from SOF through the last CRC bit, stuff bits included in the run count.
- After STUFF_LEN equal driven bits, the next tx_point drives the complement and the field position does not advance.
- The stuff bit itself starts a new run of length 1.
- A stuff bit required after CRC bit 0 is emitted before FIN.

Abort and reset:
- abort_tx=1 in any state: next cycle goes to IDLE with tx_bit=1, tx_busy=0 and no tx_done. Abort has priority over tx_request in the same cycle.
- rst mid-frame returns all outputs to their reset values on the next edge.

Test Plan:
- Reset: hold rst for 3 cycles → tx_bit=1, tx_busy=0, tx_done=0, tx_crc=0.
- Stuffing: BASIC mode, d0=0x00, d1=0x00 (ID 0, DLC 0), request, then 20 tx_points → first 12 driven bits are 0,0,0,0,0,1,0,0,0,0,0,1. Total driven bits equal 19 + 15 + stuff count from the reference model. tx_done fires exactly once.
- Extended frame: EXTENDED mode, d0=0x82 (FF=1, DLC=2), ID=0x1ABCDEF0 in d1..d4, d5=0xA5, d6=0x5A → after removing stuff bits, the stream is 39 header + 16 data + 15 CRC bits. SRR=1 and IDE=1 appear at unstuffed positions 12 and 13. tx_crc matches the software CRC-15 model.
- RTR and DLC clamp: BASIC mode, d1 = RTR=1, DLC=4 → no data bits, CRC follows DLC directly. With RTR=0 and DLC=15 → exactly 64 data bits, DLC field shows 1111.
- Snapshot: after start, change d2..d9 → transmitted data equals the values held at tx_request. A second tx_request while busy leaves the frame unaffected.
- Abort: abort_tx asserted at the 10th tx_point of a frame → next cycle tx_busy=0, tx_bit=1, no tx_done. A new tx_request then starts cleanly from SOF with tx_crc=0.

Source files
------------

// File: rtl/can_tx_frame_serializer.sv
// CAN transmit frame serializer.
// On a start request, snapshots the 13-byte transmit buffer and emits the frame from SOF through
// the last CRC bit, one bit per tx_point tick. Bit stuffing and CRC-15 are applied on the fly.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   tx_request         - one-cycle start pulse (ignored while busy)
//   abort_tx           - abort current frame (priority over tx_request)
//   tx_point           - one-cycle tick per bit time
//   extended_mode      - 0 = BASIC layout, 1 = EXTENDED layout
//   tx_data_0..12      - transmit buffer bytes
//   tx_bit             - serial bit (1 = recessive)
//   tx_busy            - frame in progress
//   tx_done            - one-cycle pulse at end of frame
//   tx_crc             - running CRC-15
module can_tx_frame_serializer #(
   parameter int unsigned STUFF_LEN = 5,
   parameter logic [14:0] CRC_POLY  = 15'h4599
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tx_request,
   input  logic        abort_tx,
   input  logic        tx_point,
   input  logic        extended_mode,
   input  logic [7:0]  tx_data_0,
   input  logic [7:0]  tx_data_1,
   input  logic [7:0]  tx_data_2,
   input  logic [7:0]  tx_data_3,
   input  logic [7:0]  tx_data_4,
   input  logic [7:0]  tx_data_5,
   input  logic [7:0]  tx_data_6,
   input  logic [7:0]  tx_data_7,
   input  logic [7:0]  tx_data_8,
   input  logic [7:0]  tx_data_9,
   input  logic [7:0]  tx_data_10,
   input  logic [7:0]  tx_data_11,
   input  logic [7:0]  tx_data_12,
   output logic        tx_bit,
   output logic        tx_busy,
   output logic        tx_done,
   output logic [14:0] tx_crc
);

   localparam int unsigned SW = $clog2(STUFF_LEN + 1);
   localparam logic [SW-1:0] StuffMax = SW'(STUFF_LEN);

   typedef enum logic [2:0] {StIdle, StHdr, StData, StCrc, StFin} state_t;

   state_t        state_q, state_d;
   logic [7:0]    buf_q [13];
   logic          ext_q;
   logic [6:0]    cnt_q, cnt_d;
   logic [SW-1:0] stuff_q, stuff_d;
   logic [14:0]   crc_q, crc_d;
   logic          bit_q, bit_d;
   logic          done_q, done_d;

   logic          start;
   logic          ff, rtr;
   logic [3:0]    dlc;
   logic [28:0]   id;
   logic [63:0]   data_vec;
   logic [38:0]   hdr_vec;
   logic [6:0]    hdr_last;
   logic [6:0]    data_bits;
   logic [38:0]   hdr_sh;
   logic [63:0]   data_sh;
   logic [14:0]   crc_sh;
   logic          field_bit;
   logic          stuff_now;
   logic          crc_nxt;

   assign start   = (state_q == StIdle) && tx_request && !abort_tx;
   assign tx_bit  = bit_q;
   assign tx_busy = (state_q != StIdle);
   assign tx_done = done_q;
   assign tx_crc  = crc_q;

   // Shadow copy of the buffer; only loaded at start so later writes cannot disturb the frame.
   always_ff @(posedge clk) begin
      if (start) begin
         buf_q[0]  <= tx_data_0;
         buf_q[1]  <= tx_data_1;
         buf_q[2]  <= tx_data_2;
         buf_q[3]  <= tx_data_3;
         buf_q[4]  <= tx_data_4;
         buf_q[5]  <= tx_data_5;
         buf_q[6]  <= tx_data_6;
         buf_q[7]  <= tx_data_7;
         buf_q[8]  <= tx_data_8;
         buf_q[9]  <= tx_data_9;
         buf_q[10] <= tx_data_10;
         buf_q[11] <= tx_data_11;
         buf_q[12] <= tx_data_12;
         ext_q     <= extended_mode;
      end
   end

   // Field decode from the shadow buffer.
   always_comb begin
      ff  = 1'b0;
      rtr = buf_q[1][4];
      dlc = buf_q[1][3:0];
      id  = {18'd0, buf_q[0], buf_q[1][7:5]};
      data_vec = {buf_q[2], buf_q[3], buf_q[4], buf_q[5],
                  buf_q[6], buf_q[7], buf_q[8], buf_q[9]};
      if (ext_q) begin
         ff  = buf_q[0][7];
         rtr = buf_q[0][6];
         dlc = buf_q[0][3:0];
         if (ff) begin
            id = {buf_q[1], buf_q[2], buf_q[3], buf_q[4][7:3]};
            data_vec = {buf_q[5], buf_q[6], buf_q[7], buf_q[8],
                        buf_q[9], buf_q[10], buf_q[11], buf_q[12]};
         end else begin
            id = {18'd0, buf_q[1], buf_q[2][7:5]};
            data_vec = {buf_q[3], buf_q[4], buf_q[5], buf_q[6],
                        buf_q[7], buf_q[8], buf_q[9], buf_q[10]};
         end
      end
      // Header is left-aligned in a 39-bit vector so both layouts shift out of bit 38.
      if (ff) begin
         hdr_vec  = {1'b0, id[28:18], 2'b11, id[17:0], rtr, 2'b00, dlc};
         hdr_last = 7'd38;
      end else begin
         hdr_vec  = {1'b0, id[10:0], rtr, 2'b00, dlc, 20'd0};
         hdr_last = 7'd18;
      end
      // DLC above 8 still carries only 8 data bytes.
      if (rtr)         data_bits = 7'd0;
      else if (dlc[3]) data_bits = 7'd64;
      else             data_bits = {1'b0, dlc[2:0], 3'b000};
   end

   always_comb begin
      hdr_sh  = hdr_vec << cnt_q;
      data_sh = data_vec << cnt_q;
      crc_sh  = crc_q << cnt_q[3:0];
      unique case (state_q)
         StHdr:   field_bit = hdr_sh[38];
         StData:  field_bit = data_sh[63];
         StCrc:   field_bit = crc_sh[14];
         default: field_bit = 1'b1;
      endcase
   end

   assign stuff_now = (stuff_q == StuffMax);
   assign crc_nxt   = crc_q[14] ^ field_bit;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stuff_d = stuff_q;
      crc_d   = crc_q;
      bit_d   = bit_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StHdr;
               cnt_d   = 7'd0;
               stuff_d = '0;
               crc_d   = 15'd0;
               bit_d   = 1'b1;
            end
         end
         StHdr, StData, StCrc: begin
            if (tx_point) begin
               if (stuff_now) begin
                  bit_d   = ~bit_q;
                  stuff_d = SW'(1);
                  // cnt 15 in CRC marks a pending stuff bit after CRC bit 0.
                  if (state_q == StCrc && cnt_q == 7'd15) state_d = StFin;
               end else begin
                  bit_d   = field_bit;
                  stuff_d = (field_bit == bit_q && stuff_q != '0) ? stuff_q + SW'(1) : SW'(1);
                  cnt_d   = cnt_q + 7'd1;
                  if (state_q != StCrc) begin
                     crc_d = {crc_q[13:0], 1'b0} ^ (crc_nxt ? CRC_POLY : 15'd0);
                  end
                  if (state_q == StHdr && cnt_q == hdr_last) begin
                     cnt_d   = 7'd0;
                     state_d = (data_bits == 7'd0) ? StCrc : StData;
                  end
                  if (state_q == StData && cnt_q == data_bits - 7'd1) begin
                     cnt_d   = 7'd0;
                     state_d = StCrc;
                  end
                  if (state_q == StCrc && cnt_q == 7'd14 && stuff_d != StuffMax) begin
                     state_d = StFin;
                  end
               end
            end
         end
         StFin: begin
            if (tx_point) begin
               state_d = StIdle;
               bit_d   = 1'b1;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
      if (abort_tx) begin
         state_d = StIdle;
         bit_d   = 1'b1;
         done_d  = 1'b0;
         stuff_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 7'd0;
         stuff_q <= '0;
         crc_q   <= 15'd0;
         bit_q   <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stuff_q <= stuff_d;
         crc_q   <= crc_d;
         bit_q   <= bit_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_can_tx_frame_serializer.sv
module tb_can_tx_frame_serializer;

   logic        clk = 1'b0;
   logic        rst, tx_request, abort_tx, tx_point, extended_mode;
   logic [7:0]  d [13];
   logic        tx_bit, tx_busy, tx_done;
   logic [14:0] tx_crc;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int dc0;
   bit ub[$];
   bit exp_s[$];
   bit cap[$];
   bit ds[$];
   logic [14:0] exp_crc;
   logic [11:0] first12;
   logic [3:0]  dlc_seen;

   can_tx_frame_serializer dut (
      .clk(clk), .rst(rst), .tx_request(tx_request), .abort_tx(abort_tx),
      .tx_point(tx_point), .extended_mode(extended_mode),
      .tx_data_0(d[0]), .tx_data_1(d[1]), .tx_data_2(d[2]), .tx_data_3(d[3]),
      .tx_data_4(d[4]), .tx_data_5(d[5]), .tx_data_6(d[6]), .tx_data_7(d[7]),
      .tx_data_8(d[8]), .tx_data_9(d[9]), .tx_data_10(d[10]), .tx_data_11(d[11]),
      .tx_data_12(d[12]),
      .tx_bit(tx_bit), .tx_busy(tx_busy), .tx_done(tx_done), .tx_crc(tx_crc)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (tx_done) done_cnt++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic start();
      tx_request = 1'b1;
      cycle();
      tx_request = 1'b0;
      cycle();
   endtask

   // One tx_point tick, sample the result, then one quiet cycle.
   task automatic point(output bit b, output bit bz);
      tx_point = 1'b1;
      cycle();
      tx_point = 1'b0;
      b  = tx_bit;
      bz = tx_busy;
      cycle();
   endtask

   task automatic run_frame(input string tag);
      bit b, bz, fin;
      cap.delete();
      fin = 1'b0;
      for (int k = 0; k < 400; k++) begin
         point(b, bz);
         if (!bz) begin
            fin = 1'b1;
            break;
         end
         cap.push_back(b);
      end
      chk({tag, "_ended"}, 64'(fin), 64'd1);
   endtask

   task automatic push(input logic [63:0] v, input int w);
      for (int i = w - 1; i >= 0; i--) ub.push_back(v[i]);
   endtask

   // Append CRC to the unstuffed header+data in ub, then build the stuffed stream.
   task automatic model();
      logic [14:0] c;
      bit n, b, last;
      int run;
      c = 15'd0;
      foreach (ub[i]) begin
         n = c[14] ^ ub[i];
         c = {c[13:0], 1'b0};
         if (n) c = c ^ 15'h4599;
      end
      exp_crc = c;
      push(64'(c), 15);
      exp_s.delete();
      run = 0;
      last = 1'b1;
      foreach (ub[i]) begin
         b = ub[i];
         exp_s.push_back(b);
         if (run != 0 && b == last) run++;
         else run = 1;
         last = b;
         if (run == 5) begin
            exp_s.push_back(~b);
            last = ~b;
            run = 1;
         end
      end
   endtask

   task automatic destuff();
      bit last;
      int run;
      ds.delete();
      run = 0;
      last = 1'b1;
      foreach (cap[i]) begin
         if (run == 5) begin
            run = 1;
            last = cap[i];
         end else begin
            ds.push_back(cap[i]);
            if (run != 0 && cap[i] == last) run++;
            else run = 1;
            last = cap[i];
         end
      end
   endtask

   task automatic cmp_stream(input string tag);
      int mism, n;
      chk({tag, "_len"}, 64'(cap.size()), 64'(exp_s.size()));
      n = (cap.size() < exp_s.size()) ? cap.size() : exp_s.size();
      mism = 0;
      for (int i = 0; i < n; i++) if (cap[i] != exp_s[i]) mism++;
      chk({tag, "_bits"}, 64'(mism), 64'd0);
      chk({tag, "_crc"}, 64'(tx_crc), 64'(exp_crc));
   endtask

   initial begin
      bit b, bz;
      rst = 1'b1; tx_request = 1'b0; abort_tx = 1'b0; tx_point = 1'b0; extended_mode = 1'b0;
      for (int i = 0; i < 13; i++) d[i] = 8'h00;
      repeat (3) cycle();
      chk("rst_bit", 64'(tx_bit), 64'd1);
      chk("rst_busy", 64'(tx_busy), 64'd0);
      chk("rst_done", 64'(tx_done), 64'd0);
      chk("rst_crc", 64'(tx_crc), 64'd0);
      rst = 1'b0;
      cycle();

      // A: all-zero BASIC frame exercises stuffing; tx_point coincident with request.
      ub.delete();
      push(64'd0, 19);
      model();
      dc0 = done_cnt;
      tx_request = 1'b1; tx_point = 1'b1;
      cycle();
      tx_request = 1'b0; tx_point = 1'b0;
      chk("a_busy", 64'(tx_busy), 64'd1);
      chk("a_no_sof", 64'(tx_bit), 64'd1);
      cycle();
      run_frame("a");
      for (int i = 0; i < 12; i++) first12[11 - i] = cap[i];
      chk("a_first12", 64'(first12), 64'b000001000001);
      cmp_stream("a");
      chk("a_done_once", 64'(done_cnt - dc0), 64'd1);
      chk("a_idle_bit", 64'(tx_bit), 64'd1);

      // B: extended frame, ID 0x1ABCDEF0, DLC 2.
      extended_mode = 1'b1;
      d[0] = 8'h82; d[1] = 8'hD5; d[2] = 8'hE6; d[3] = 8'hF7; d[4] = 8'h80;
      d[5] = 8'hA5; d[6] = 8'h5A;
      ub.delete();
      push(64'd0, 1); push(64'h1ABCDEF0 >> 18, 11); push(64'd3, 2);
      push(64'h1ABCDEF0 & 64'h3FFFF, 18); push(64'd0, 1); push(64'd0, 2); push(64'd2, 4);
      push(64'hA55A, 16);
      model();
      start();
      run_frame("b");
      destuff();
      chk("b_unstuffed_len", 64'(ds.size()), 64'd70);
      if (ds.size() > 13) begin
         chk("b_srr", 64'(ds[12]), 64'd1);
         chk("b_ide", 64'(ds[13]), 64'd1);
      end
      cmp_stream("b");

      // C: BASIC RTR with DLC 4 - no data field.
      extended_mode = 1'b0;
      d[0] = 8'h55; d[1] = 8'hB4;
      ub.delete();
      push(64'd0, 1); push({53'd0, 8'h55, 3'b101}, 11); push(64'd1, 1); push(64'd0, 2);
      push(64'd4, 4);
      model();
      start();
      run_frame("c");
      destuff();
      chk("c_unstuffed_len", 64'(ds.size()), 64'd34);
      cmp_stream("c");

      // D: DLC 15 clamps to 64 data bits; buffer rewritten and re-requested mid-frame.
      d[0] = 8'hA3; d[1] = 8'h4F;
      d[2] = 8'h11; d[3] = 8'h22; d[4] = 8'h33; d[5] = 8'h44;
      d[6] = 8'h55; d[7] = 8'h66; d[8] = 8'h77; d[9] = 8'h88;
      ub.delete();
      push(64'd0, 1); push({53'd0, 8'hA3, 3'b010}, 11); push(64'd0, 1); push(64'd0, 2);
      push(64'hF, 4); push(64'h1122334455667788, 64);
      model();
      dc0 = done_cnt;
      start();
      for (int i = 2; i < 10; i++) d[i] = 8'hEE;
      d[1] = 8'h00;
      tx_request = 1'b1;
      cycle();
      tx_request = 1'b0;
      run_frame("d");
      destuff();
      chk("d_unstuffed_len", 64'(ds.size()), 64'd98);
      if (ds.size() > 18) begin
         for (int i = 0; i < 4; i++) dlc_seen[3 - i] = ds[15 + i];
         chk("d_dlc_field", 64'(dlc_seen), 64'hF);
      end
      cmp_stream("d");
      chk("d_done_once", 64'(done_cnt - dc0), 64'd1);

      // E: abort on the 10th tx_point, then a clean restart of frame D.
      d[1] = 8'h4F;
      d[2] = 8'h11; d[3] = 8'h22; d[4] = 8'h33; d[5] = 8'h44;
      d[6] = 8'h55; d[7] = 8'h66; d[8] = 8'h77; d[9] = 8'h88;
      dc0 = done_cnt;
      start();
      for (int i = 0; i < 9; i++) point(b, bz);
      tx_point = 1'b1; abort_tx = 1'b1;
      cycle();
      tx_point = 1'b0; abort_tx = 1'b0;
      chk("e_abort_busy", 64'(tx_busy), 64'd0);
      chk("e_abort_bit", 64'(tx_bit), 64'd1);
      repeat (3) cycle();
      chk("e_no_done", 64'(done_cnt - dc0), 64'd0);
      tx_request = 1'b1;
      cycle();
      tx_request = 1'b0;
      chk("e_restart_busy", 64'(tx_busy), 64'd1);
      chk("e_restart_crc", 64'(tx_crc), 64'd0);
      cycle();
      run_frame("e");
      cmp_stream("e");

      // F: synchronous reset mid-frame.
      start();
      for (int i = 0; i < 5; i++) point(b, bz);
      rst = 1'b1;
      cycle();
      chk("f_rst_busy", 64'(tx_busy), 64'd0);
      chk("f_rst_bit", 64'(tx_bit), 64'd1);
      chk("f_rst_done", 64'(tx_done), 64'd0);
      chk("f_rst_crc", 64'(tx_crc), 64'd0);
      rst = 1'b0;
      cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
